// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, icache geometry, FSM encodings.
// Pure declarations; no timing or flow-control behaviour.
package inst_fetch_pkg;

    localparam int AddrBus        = 32;
    localparam int InstBus        = 32;
    localparam int ICacheSize     = 64;
    localparam int ICacheIndexBus = $clog2(ICacheSize);
    localparam int ICacheTagBus   = AddrBus - ICacheIndexBus - 2;

    localparam logic Enable  = 1'b1;
    localparam logic Disable = 1'b0;

    localparam logic [InstBus-1:0] ZeroWord = '0;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_BUSY = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    function automatic logic [AddrBus-1:0] next_pc(input logic [AddrBus-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache: combinational hit/data lookup, fill written at the edge.
// Latency: 0-cycle read, fill visible next cycle; no backpressure, fills always accepted.
module inst_fetch_icache import inst_fetch_pkg::*; (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ICacheIndexBus-1:0] rd_idx,
    input  logic [ICacheTagBus-1:0]   rd_tag,
    output logic                      hit,
    output logic [InstBus-1:0]        rd_data,
    input  logic                      fill,
    input  logic [ICacheIndexBus-1:0] wr_idx,
    input  logic [ICacheTagBus-1:0]   wr_tag,
    input  logic [InstBus-1:0]        wr_data
);

    logic [ICacheSize-1:0]   valid_q;
    logic [ICacheSize-1:0]   valid_d;
    logic [ICacheTagBus-1:0] tag_mem  [ICacheSize];
    logic [InstBus-1:0]      data_mem [ICacheSize];

    always_comb begin
        valid_d = valid_q;
        if (fill) valid_d[wr_idx] = Enable;
    end

    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else     valid_q <= valid_d;
    end

    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    // Reads see pre-edge contents, so a same-index fill returns the old line.
    assign hit     = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, miss FSM (IDLE/BUSY/DROP) and registered IF/ID outputs over a 64-line icache.
// Latency: hit 1 cycle, miss 1 cycle after mem_done_i; stall_i holds outputs, rdy low freezes everything.
module inst_fetch import inst_fetch_pkg::*; (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               stall_i,
    input  logic               jump_i,
    input  logic [AddrBus-1:0] jump_addr_i,
    output logic               mem_req_o,
    output logic [AddrBus-1:0] mem_addr_o,
    input  logic               mem_done_i,
    input  logic [InstBus-1:0] mem_inst_i,
    output logic [AddrBus-1:0] pc_o,
    output logic [InstBus-1:0] inst_o,
    output logic               inst_valid_o
);

    fetch_state_e       state_q, state_d;
    logic [AddrBus-1:0] pc_q, pc_d;
    logic [AddrBus-1:0] req_addr_q, req_addr_d;
    logic [AddrBus-1:0] pc_out_q, pc_out_d;
    logic [InstBus-1:0] inst_out_q, inst_out_d;
    logic               inst_valid_q, inst_valid_d;

    logic               hit;
    logic [InstBus-1:0] hit_data;
    logic               fill;

    inst_fetch_icache u_icache (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (pc_q[ICacheIndexBus+1:2]),
        .rd_tag  (pc_q[AddrBus-1:ICacheIndexBus+2]),
        .hit     (hit),
        .rd_data (hit_data),
        .fill    (fill),
        .wr_idx  (req_addr_q[ICacheIndexBus+1:2]),
        .wr_tag  (req_addr_q[AddrBus-1:ICacheIndexBus+2]),
        .wr_data (mem_inst_i)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        pc_out_d     = pc_out_q;
        inst_out_d   = inst_out_q;
        inst_valid_d = inst_valid_q;
        fill         = Disable;

        if (rdy) begin
            case (state_q)
                FETCH_IDLE: begin
                    if (jump_i) begin
                        pc_d         = jump_addr_i;
                        inst_out_d   = ZeroWord;
                        inst_valid_d = Disable;
                    end else if (!stall_i) begin
                        if (hit) begin
                            pc_out_d     = pc_q;
                            inst_out_d   = hit_data;
                            inst_valid_d = Enable;
                            pc_d         = next_pc(pc_q);
                        end else begin
                            req_addr_d   = pc_q;
                            state_d      = FETCH_BUSY;
                            inst_valid_d = Disable;
                        end
                    end
                end
                FETCH_BUSY: begin
                    if (mem_done_i) begin
                        fill    = Enable;
                        state_d = FETCH_IDLE;
                        if (jump_i) begin
                            pc_d         = jump_addr_i;
                            inst_out_d   = ZeroWord;
                            inst_valid_d = Disable;
                        end else if (!stall_i) begin
                            pc_out_d     = req_addr_q;
                            inst_out_d   = mem_inst_i;
                            inst_valid_d = Enable;
                            pc_d         = next_pc(req_addr_q);
                        end
                    end else if (jump_i) begin
                        // The request stays live at the controller; its data is discarded in DROP.
                        state_d      = FETCH_DROP;
                        pc_d         = jump_addr_i;
                        inst_out_d   = ZeroWord;
                        inst_valid_d = Disable;
                    end else if (!stall_i) begin
                        inst_valid_d = Disable;
                    end
                end
                FETCH_DROP: begin
                    if (mem_done_i) begin
                        fill    = Enable;
                        state_d = FETCH_IDLE;
                    end
                    if (jump_i) begin
                        pc_d         = jump_addr_i;
                        inst_out_d   = ZeroWord;
                        inst_valid_d = Disable;
                    end
                end
                default: state_d = FETCH_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_IDLE;
            pc_q         <= '0;
            req_addr_q   <= '0;
            pc_out_q     <= '0;
            inst_out_q   <= ZeroWord;
            inst_valid_q <= Disable;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            pc_out_q     <= pc_out_d;
            inst_out_q   <= inst_out_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign mem_req_o    = (state_q != FETCH_IDLE);
    assign mem_addr_o   = req_addr_q;
    assign pc_o         = pc_out_q;
    assign inst_o       = inst_out_q;
    assign inst_valid_o = inst_valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed vector bench for inst_fetch: one record per clock, outputs checked 1ns after the edge.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst, rdy, stall_i, jump_i, mem_done_i;
    logic [31:0] jump_addr_i, mem_inst_i;
    logic        mem_req_o, inst_valid_o;
    logic [31:0] mem_addr_o, pc_o, inst_o;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          rst, rdy, stall, jump, done;
        logic [31:0] ja, mi;
        bit          e_req;
        logic [31:0] e_addr, e_pc, e_inst;
        bit          e_vld;
    } vec_t;

    vec_t tbl[$];

    inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .stall_i      (stall_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_done_i   (mem_done_i),
        .mem_inst_i   (mem_inst_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .inst_valid_o (inst_valid_o)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(input bit r, input bit rd, input bit st, input bit jp,
                               input logic [31:0] ja, input bit dn, input logic [31:0] mi,
                               input bit er, input logic [31:0] ea, input logic [31:0] ep,
                               input logic [31:0] ei, input bit ev);
        vec_t t;
        t.rst = r;   t.rdy = rd; t.stall = st; t.jump = jp; t.ja = ja;
        t.done = dn; t.mi = mi;  t.e_req = er; t.e_addr = ea;
        t.e_pc = ep; t.e_inst = ei; t.e_vld = ev;
        return t;
    endfunction

    task automatic apply(input vec_t t, input string name);
        rst         = t.rst;
        rdy         = t.rdy;
        stall_i     = t.stall;
        jump_i      = t.jump;
        jump_addr_i = t.ja;
        mem_done_i  = t.done;
        mem_inst_i  = t.mi;
        @(posedge clk);
        #1;
        n_checks++;
        if ({mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o} ===
            {t.e_req, t.e_addr, t.e_pc, t.e_inst, t.e_vld}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got req=%0b addr=%h pc=%h inst=%h vld=%0b, want req=%0b addr=%h pc=%h inst=%h vld=%0b",
                     name, mem_req_o, mem_addr_o, pc_o, inst_o, inst_valid_o,
                     t.e_req, t.e_addr, t.e_pc, t.e_inst, t.e_vld);
        end
    endtask

    initial begin
        //                 rst rdy st jp ja            dn mi            req addr          pc            inst          vld
        // cold miss at 0, fill after 4 busy cycles, next miss at 4
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h0,        32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'h13,       0, 32'h0,        32'h0,        32'h13,       0 | 1));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        32'h0,        32'h13,       0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'h00100093, 0, 32'h4,        32'h4,        32'h00100093, 1));
        // loop back to 0: hits, no request
        tbl.push_back(v(0, 1, 0, 1, 32'h0,        0, 32'h0,        0, 32'h4,        32'h4,        32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h4,        32'h0,        32'h13,       1));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h4,        32'h4,        32'h00100093, 1));
        // miss at 8, redirect to 0x100 while busy -> DROP
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h4,        32'h00100093, 0));
        tbl.push_back(v(0, 1, 0, 1, 32'h100,      0, 32'h0,        1, 32'h8,        32'h4,        32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h8,        32'h4,        32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'hdeadbeef, 0, 32'h8,        32'h4,        32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h100,      32'h4,        32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'h11111111, 0, 32'h100,      32'h100,      32'h11111111, 1));
        // jump together with stall
        tbl.push_back(v(0, 1, 1, 1, 32'h10,       0, 32'h0,        0, 32'h100,      32'h100,      32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h10,       32'h100,      32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'h22222222, 0, 32'h10,       32'h10,       32'h22222222, 1));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h14,       32'h10,       32'h22222222, 0));
        // fill under stall: held, then the line hits
        tbl.push_back(v(0, 1, 1, 0, 32'h0,        1, 32'h33333333, 0, 32'h14,       32'h10,       32'h22222222, 0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h14,       32'h14,       32'h33333333, 1));
        // hit stream at 0x10 with a 3-cycle stall
        tbl.push_back(v(0, 1, 0, 1, 32'h10,       0, 32'h0,        0, 32'h14,       32'h14,       32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h14,       32'h10,       32'h22222222, 1));
        tbl.push_back(v(0, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h14,       32'h10,       32'h22222222, 1));
        tbl.push_back(v(0, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h14,       32'h10,       32'h22222222, 1));
        tbl.push_back(v(0, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h14,       32'h10,       32'h22222222, 1));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h14,       32'h14,       32'h33333333, 1));
        // rdy low freezes IDLE and BUSY, done ignored
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h44,       0, 32'h14,       32'h14,       32'h33333333, 1));
        tbl.push_back(v(0, 0, 0, 1, 32'h200,      1, 32'h44,       0, 32'h14,       32'h14,       32'h33333333, 1));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h18,       32'h14,       32'h33333333, 0));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        1, 32'h55,       1, 32'h18,       32'h14,       32'h33333333, 0));
        tbl.push_back(v(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h18,       32'h14,       32'h33333333, 0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'h66666666, 0, 32'h18,       32'h18,       32'h66666666, 1));
        // 0x114 aliases 0x14 at index 5 and evicts it
        tbl.push_back(v(0, 1, 0, 1, 32'h114,      0, 32'h0,        0, 32'h18,       32'h18,       32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h114,      32'h18,       32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'h77777777, 0, 32'h114,      32'h114,      32'h77777777, 1));
        tbl.push_back(v(0, 1, 0, 1, 32'h14,       0, 32'h0,        0, 32'h114,      32'h114,      32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h14,       32'h114,      32'h0,        0));
        // done and jump together: line filled, word discarded
        tbl.push_back(v(0, 1, 0, 1, 32'h300,      1, 32'h88888888, 0, 32'h14,       32'h114,      32'h0,        0));
        tbl.push_back(v(0, 1, 0, 1, 32'h14,       0, 32'h0,        0, 32'h14,       32'h114,      32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h14,       32'h14,       32'h88888888, 1));
        // second jump while in DROP retargets pc
        tbl.push_back(v(0, 1, 0, 1, 32'h400,      0, 32'h0,        0, 32'h14,       32'h14,       32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h400,      32'h14,       32'h0,        0));
        tbl.push_back(v(0, 1, 0, 1, 32'h500,      0, 32'h0,        1, 32'h400,      32'h14,       32'h0,        0));
        tbl.push_back(v(0, 1, 0, 1, 32'h18,       0, 32'h0,        1, 32'h400,      32'h14,       32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        1, 32'h99999999, 0, 32'h400,      32'h14,       32'h0,        0));
        tbl.push_back(v(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h400,      32'h18,       32'h66666666, 1));

        // reset overrides rdy, stall, jump and done
        apply(v(1, 0, 1, 1, 32'h40, 1, 32'hff, 0, 32'h0, 32'h0, 32'h0, 0), "reset_override");
        apply(v(1, 1, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0, 32'h0, 32'h0, 0), "reset_hold");

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("row%0d", i + 1));
        end

        // reset mid-miss: request dropped, cache cleared, late done ignored
        apply(v(0, 1, 0, 0, 32'h0,        0, 32'h0,   1, 32'h1c,       32'h18,       32'h66666666, 1'b0), "busy_before_rst");
        apply(v(1, 1, 1, 1, 32'h18,       1, 32'h1,   0, 32'h0,        32'h0,        32'h0,        0), "rst_mid_busy");
        apply(v(0, 1, 0, 1, 32'h18,       1, 32'habc, 0, 32'h0,        32'h0,        32'h0,        0), "late_done_ignored");
        apply(v(0, 1, 0, 0, 32'h0,        0, 32'h0,   1, 32'h18,       32'h0,        32'h0,        0), "cache_cleared");
        apply(v(0, 1, 0, 0, 32'h0,        1, 32'habc, 0, 32'h18,       32'h18,       32'habc,      1), "refill_18");
        // pc wraps from 0xfffffffc to 0
        apply(v(0, 1, 0, 1, 32'hfffffffc, 0, 32'h0,   0, 32'h18,       32'h18,       32'h0,        0), "jump_top");
        apply(v(0, 1, 0, 0, 32'h0,        0, 32'h0,   1, 32'hfffffffc, 32'h18,       32'h0,        0), "miss_top");
        apply(v(0, 1, 0, 0, 32'h0,        1, 32'hbad, 0, 32'hfffffffc, 32'hfffffffc, 32'hbad,      1), "fill_top");
        apply(v(0, 1, 0, 0, 32'h0,        0, 32'h0,   1, 32'h0,        32'hfffffffc, 32'hbad,      0), "pc_wrap");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
